// File: rtl/gwa_pkg.sv
// rtl/gwa_pkg.sv - shared constants and helpers for the gwa input conditioning stage
package gwa_pkg;

    localparam int CH_EU1 = 0;
    localparam int CH_EU2 = 1;
    localparam int CH_WT  = 2;
    localparam int NUM_CH = 3;

    localparam int DEB_CYCLES_DEF = 4;
    localparam int GAP_CYCLES_DEF = 2;

    localparam int GAP_W = 4;

    typedef logic [NUM_CH-1:0] ch_vec_t;

    // Lowest set bit wins, which gives eu1 > eu2 > wt with the channel indices above.
    function automatic ch_vec_t pick_first(input ch_vec_t req);
        return req & (~req + NUM_CH'(1));
    endfunction

endpackage

// File: rtl/gwa_debounce.sv
// rtl/gwa_debounce.sv - two-flop synchroniser and counting debouncer for one raw input
module gwa_debounce
    import gwa_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic rise
);

    localparam int CW = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    logic          meta;
    logic          s;
    logic          deb;
    logic [CW-1:0] cnt;
    logic          flip;

    assign flip = (s != deb) && (cnt == CNT_LAST);

    // High on the edge where the accepted level is about to go 0->1.
    assign rise = flip & s;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta <= 1'b0;
            s    <= 1'b0;
            deb  <= 1'b0;
            cnt  <= '0;
        end else begin
            meta <= raw;
            s    <= meta;
            if (s == deb) begin
                cnt <= '0;
            end else if (flip) begin
                deb <= s;
                cnt <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/gwa_input_cond.sv
// rtl/gwa_input_cond.sv - debounced, paced event issue for the vending FSM; GWA_COIN_CNT_EN adds coin counters
module gwa_input_cond
    import gwa_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEF,
    parameter int GAP_CYCLES = GAP_CYCLES_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       coin1_raw,
    input  logic       coin2_raw,
    input  logic       key_raw,
    output logic       eu1,
    output logic       eu2,
    output logic       wt,
`ifdef GWA_COIN_CNT_EN
    output logic       ovf,
    output logic [7:0] cnt1,
    output logic [7:0] cnt2
`else
    output logic       ovf
`endif
);

    ch_vec_t           raw_vec;
    ch_vec_t           rise;
    ch_vec_t           pending;
    ch_vec_t           grant;
    ch_vec_t           ev;
    logic [GAP_W-1:0]  gap;
    logic              idle;

    assign raw_vec[CH_EU1] = coin1_raw;
    assign raw_vec[CH_EU2] = coin2_raw;
    assign raw_vec[CH_WT]  = key_raw;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_deb
        gwa_debounce #(
            .DEB_CYCLES (DEB_CYCLES)
        ) u_deb (
            .clk  (clk),
            .rst  (rst),
            .raw  (raw_vec[i]),
            .rise (rise[i])
        );
    end

    assign idle  = (gap == '0);
    assign grant = idle ? pick_first(pending) : '0;

    // A rise on the channel being granted re-arms it rather than counting as a drop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending <= '0;
            ev      <= '0;
            gap     <= '0;
            ovf     <= 1'b0;
        end else begin
            pending <= (pending & ~grant) | rise;
            ev      <= grant;
            if (|(rise & pending & ~grant)) begin
                ovf <= 1'b1;
            end
            if (|grant) begin
                gap <= GAP_W'(GAP_CYCLES);
            end else if (!idle) begin
                gap <= gap - GAP_W'(1);
            end
        end
    end

    assign eu1 = ev[CH_EU1];
    assign eu2 = ev[CH_EU2];
    assign wt  = ev[CH_WT];

`ifdef GWA_COIN_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt1 <= '0;
            cnt2 <= '0;
        end else begin
            if (grant[CH_EU1] && (cnt1 != 8'hFF)) begin
                cnt1 <= cnt1 + 8'd1;
            end
            if (grant[CH_EU2] && (cnt2 != 8'hFF)) begin
                cnt2 <= cnt2 + 8'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_gwa_input_cond.sv
// tb/tb_gwa_input_cond.sv - directed self-checking bench for gwa_input_cond
module tb_gwa_input_cond;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic coin1_raw, coin2_raw, key_raw;
    logic eu1, eu2, wt, ovf;
    logic b_coin1, b_coin2, b_key;
    logic b_eu1, b_eu2, b_wt, b_ovf;
`ifdef GWA_COIN_CNT_EN
    logic [7:0] cnt1, cnt2, b_cnt1, b_cnt2;
`endif

    gwa_input_cond dut (
        .clk       (clk),
        .rst       (rst),
        .coin1_raw (coin1_raw),
        .coin2_raw (coin2_raw),
        .key_raw   (key_raw),
        .eu1       (eu1),
        .eu2       (eu2),
        .wt        (wt),
`ifdef GWA_COIN_CNT_EN
        .ovf       (ovf),
        .cnt1      (cnt1),
        .cnt2      (cnt2)
`else
        .ovf       (ovf)
`endif
    );

    // Short debounce and long gap so a second edge can arrive while the first is still queued.
    gwa_input_cond #(
        .DEB_CYCLES (2),
        .GAP_CYCLES (15)
    ) dut_b (
        .clk       (clk),
        .rst       (rst),
        .coin1_raw (b_coin1),
        .coin2_raw (b_coin2),
        .key_raw   (b_key),
        .eu1       (b_eu1),
        .eu2       (b_eu2),
        .wt        (b_wt),
`ifdef GWA_COIN_CNT_EN
        .ovf       (b_ovf),
        .cnt1      (b_cnt1),
        .cnt2      (b_cnt2)
`else
        .ovf       (b_ovf)
`endif
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_eu1 = 0, n_eu2 = 0, n_wt = 0;
    int c_eu1 = 0, c_eu2 = 0, c_wt = 0;
    int nb_eu1 = 0, nb_wt = 0, cb_eu1 = 0, cb_wt = 0;
    int multi_hot = 0, wide = 0;
    logic p_eu1 = 1'b0, p_eu2 = 1'b0, p_wt = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (eu1) begin n_eu1 <= n_eu1 + 1; c_eu1 <= cyc; end
        if (eu2) begin n_eu2 <= n_eu2 + 1; c_eu2 <= cyc; end
        if (wt)  begin n_wt  <= n_wt + 1;  c_wt  <= cyc; end
        if (b_eu1) begin nb_eu1 <= nb_eu1 + 1; cb_eu1 <= cyc; end
        if (b_wt)  begin nb_wt  <= nb_wt + 1;  cb_wt  <= cyc; end
        if ((int'(eu1) + int'(eu2) + int'(wt) > 1) || (int'(b_eu1) + int'(b_eu2) + int'(b_wt) > 1))
            multi_hot <= multi_hot + 1;
        if ((eu1 && p_eu1) || (eu2 && p_eu2) || (wt && p_wt))
            wide <= wide + 1;
        p_eu1 <= eu1;
        p_eu2 <= eu2;
        p_wt  <= wt;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) @(posedge clk);
        #1;
    endtask

    int c0;
    int base1, base2, basew;

    initial begin
        rst = 1'b0;
        coin1_raw = 1'b0; coin2_raw = 1'b0; key_raw = 1'b0;
        b_coin1 = 1'b0; b_coin2 = 1'b0; b_key = 1'b0;
        tick(3);
        check("rst_outs", {29'd0, eu1, eu2, wt}, 0);
        check("rst_ovf", ovf, 0);
        check("rst_b_ovf", b_ovf, 0);
        rst = 1'b1;
        tick(2);

        // single coin1 event: pulse only in the cycle after edge 6
        coin1_raw = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            check($sformatf("t1_eu1_e%0d", i), eu1, (i == 6) ? 1 : 0);
            check($sformatf("t1_other_e%0d", i), {29'd0, eu2, wt, ovf}, 0);
        end
        coin1_raw = 1'b0;
        tick(10);

        // coin2: short glitch, then bouncing, then stable
        base2 = n_eu2;
        coin2_raw = 1'b1; tick(3);
        coin2_raw = 1'b0; tick(8);
        check("t2_glitch", n_eu2 - base2, 0);
        repeat (3) begin
            coin2_raw = 1'b1; tick(2);
            coin2_raw = 1'b0; tick(1);
        end
        check("t2_bounce", n_eu2 - base2, 0);
        c0 = cyc;
        coin2_raw = 1'b1;
        tick(12);
        check("t2_count", n_eu2 - base2, 1);
        check("t2_cycle", c_eu2, c0 + 7);
        coin2_raw = 1'b0;
        tick(10);

        // simultaneous coin1 and key
        base1 = n_eu1; basew = n_wt;
        c0 = cyc;
        coin1_raw = 1'b1; key_raw = 1'b1;
        tick(14);
        coin1_raw = 1'b0; key_raw = 1'b0;
        check("t3_eu1_n", n_eu1 - base1, 1);
        check("t3_wt_n", n_wt - basew, 1);
        check("t3_eu1_cyc", c_eu1, c0 + 7);
        check("t3_wt_cyc", c_wt, c0 + 10);
        check("t3_ovf", ovf, 0);
        tick(10);

        // overflow on the second instance: second coin1 edge while the first is queued
        c0 = cyc;
        b_key = 1'b1; tick(2);
        b_coin1 = 1'b1; tick(2);
        b_key = 1'b0; tick(2);
        b_coin1 = 1'b0; tick(4);
        b_coin1 = 1'b1; tick(4);
        b_coin1 = 1'b0;
        tick(30);
        check("t4_wt_n", nb_wt, 1);
        check("t4_wt_cyc", cb_wt, c0 + 5);
        check("t4_eu1_n", nb_eu1, 1);
        check("t4_eu1_cyc", cb_eu1, c0 + 21);
        check("t4_ovf", b_ovf, 1);
        tick(10);
        check("t4_ovf_sticky", b_ovf, 1);

        // key held through reset, then reset again while coin1 is queued in the gap
        rst = 1'b0;
        key_raw = 1'b1;
        tick(3);
        check("t5_b_ovf_cleared", b_ovf, 0);
        c0 = cyc;
        rst = 1'b1;
        tick(2);
        coin1_raw = 1'b1;
        tick(4);
        check("t5_wt_early", wt, 0);
        tick(1);
        check("t5_wt_e6", wt, 1);
        tick(1);
        check("t5_gap_quiet", {29'd0, eu1, eu2, wt}, 0);
        base1 = n_eu1; basew = n_wt;
        rst = 1'b0;
        #1;
        check("t5_rst_outs", {29'd0, eu1, eu2, wt}, 0);
        coin1_raw = 1'b0; key_raw = 1'b0;
        tick(3);
        rst = 1'b1;
        tick(25);
        check("t5_no_eu1", n_eu1 - base1, 0);
        check("t5_no_wt", n_wt - basew, 0);

`ifdef GWA_COIN_CNT_EN
        base1 = n_eu1;
        for (int i = 0; i < 257; i++) begin
            coin1_raw = 1'b1; tick(6);
            coin1_raw = 1'b0; tick(6);
            if (i == 253) check("t6_cnt1_254", cnt1, 254);
        end
        check("t6_events", n_eu1 - base1, 257);
        check("t6_cnt1_sat", cnt1, 255);
        check("t6_cnt2", cnt2, 0);
`endif

        check("one_hot", multi_hot, 0);
        check("pulse_width", wide, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
